// File: rtl/periph_bus_pkg.sv
// periph_bus_pkg: shared state encoding and idle strobe value for the peripheral bus arbiter
package periph_bus_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_ACTIVE, ST_DONE} state_t;
  localparam logic [1:0] STROBE_IDLE = 2'b11;
  function automatic logic is_req(input logic [1:0] wn, input logic [1:0] rn);
    return (wn != STROBE_IDLE) || (rn != STROBE_IDLE);
  endfunction
endpackage

// File: rtl/periph_bus_arbiter.sv
// periph_bus_arbiter: two-master round-robin arbiter onto one peripheral register bus with ready timeout
module periph_bus_arbiter
  import periph_bus_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [10:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [1:0]  m0_write_n,
  input  logic [1:0]  m0_read_n,
  output logic [31:0] m0_rdata,
  output logic        m0_done,
  output logic        m0_err,
  input  logic [10:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [1:0]  m1_write_n,
  input  logic [1:0]  m1_read_n,
  output logic [31:0] m1_rdata,
  output logic        m1_done,
  output logic        m1_err,
  output logic [10:0] s_addr,
  output logic [31:0] s_wdata,
  output logic [1:0]  s_write_n,
  output logic [1:0]  s_read_n,
  input  logic [31:0] s_rdata,
  input  logic        s_ready,
  output logic        s_read_complete,
  output logic        busy,
  output logic        grant_id
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  state_t      r_state;
  logic        r_grant, r_last, r_err;
  logic [10:0] r_addr;
  logic [31:0] r_wdata, r_m0_rdata, r_m1_rdata;
  logic [1:0]  r_wn, r_rn;
  logic [CW-1:0] r_cnt;
  logic        w_req0, w_req1, w_pick, w_act, w_done;
  logic [1:0]  w_wn, w_rn;
  assign w_req0 = is_req(m0_write_n, m0_read_n);
  assign w_req1 = is_req(m1_write_n, m1_read_n);
  // on a tie the master not served last wins; a lone requester always wins
  assign w_pick = (w_req0 && w_req1) ? ~r_last : w_req1;
  assign w_wn   = w_pick ? m1_write_n : m0_write_n;
  assign w_rn   = w_pick ? m1_read_n : m0_read_n;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_grant    <= 1'b0;
      r_last     <= 1'b1;
      r_err      <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_wn       <= STROBE_IDLE;
      r_rn       <= STROBE_IDLE;
      r_cnt      <= '0;
      r_m0_rdata <= '0;
      r_m1_rdata <= '0;
    end else begin
      case (r_state)
        ST_IDLE: if (w_req0 || w_req1) begin
          r_state <= ST_ACTIVE;
          r_grant <= w_pick;
          r_last  <= w_pick;
          r_addr  <= w_pick ? m1_addr : m0_addr;
          r_wdata <= w_pick ? m1_wdata : m0_wdata;
          r_wn    <= w_wn;
          r_rn    <= (w_wn != STROBE_IDLE) ? STROBE_IDLE : w_rn;
          r_cnt   <= '0;
        end
        ST_ACTIVE: if (s_ready) begin
          r_state <= ST_DONE;
          r_err   <= 1'b0;
          if (r_grant) r_m1_rdata <= s_rdata;
          else r_m0_rdata <= s_rdata;
        end else begin
          r_cnt <= r_cnt + CW'(1);
          // this increment brings the count to TIMEOUT_CYCLES
          if (r_cnt == CW'(TIMEOUT_CYCLES - 1)) begin
            r_state <= ST_DONE;
            r_err   <= 1'b1;
            if (r_grant) r_m1_rdata <= 32'hFFFF_FFFF;
            else r_m0_rdata <= 32'hFFFF_FFFF;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end
  assign w_act           = r_state == ST_ACTIVE;
  assign w_done          = r_state == ST_DONE;
  assign busy            = r_state != ST_IDLE;
  assign grant_id        = r_grant;
  assign s_addr          = w_act ? r_addr : '0;
  assign s_wdata         = w_act ? r_wdata : '0;
  assign s_write_n       = w_act ? r_wn : STROBE_IDLE;
  assign s_read_n        = w_act ? r_rn : STROBE_IDLE;
  assign s_read_complete = w_done && !r_err && (r_rn != STROBE_IDLE);
  assign m0_done         = w_done && !r_grant;
  assign m1_done         = w_done && r_grant;
  assign m0_err          = m0_done && r_err;
  assign m1_err          = m1_done && r_err;
  assign m0_rdata        = r_m0_rdata;
  assign m1_rdata        = r_m1_rdata;
endmodule

// File: tb/tb_periph_bus_arbiter.sv
// tb_periph_bus_arbiter: randomized scoreboard bench for the two-master peripheral bus arbiter
module tb_periph_bus_arbiter;
  logic        clk = 1'b0, rst = 1'b1;
  logic [10:0] m0_addr, m1_addr, s_addr;
  logic [31:0] m0_wdata, m1_wdata, m0_rdata, m1_rdata, s_wdata, s_rdata;
  logic [1:0]  m0_write_n, m0_read_n, m1_write_n, m1_read_n, s_write_n, s_read_n;
  logic        m0_done, m0_err, m1_done, m1_err, s_ready, s_read_complete, busy, grant_id;
  typedef struct {
    bit          gid;
    logic [31:0] rdata;
    bit          err;
    bit          rc;
  } exp_t;
  exp_t q[$];
  int n_chk = 0, n_err = 0;
  int last_served = 1;
  always #5 clk = ~clk;
  periph_bus_arbiter #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst),
    .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_write_n(m0_write_n), .m0_read_n(m0_read_n),
    .m0_rdata(m0_rdata), .m0_done(m0_done), .m0_err(m0_err),
    .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_write_n(m1_write_n), .m1_read_n(m1_read_n),
    .m1_rdata(m1_rdata), .m1_done(m1_done), .m1_err(m1_err),
    .s_addr(s_addr), .s_wdata(s_wdata), .s_write_n(s_write_n), .s_read_n(s_read_n),
    .s_rdata(s_rdata), .s_ready(s_ready), .s_read_complete(s_read_complete),
    .busy(busy), .grant_id(grant_id)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask
  // completion monitor: every done pulse is matched against the oldest expected response
  always @(negedge clk) begin
    exp_t e;
    if (!rst && (m0_done || m1_done)) begin
      if (q.size() == 0) begin
        n_chk++;
        n_err++;
        $display("FAIL unexpected_done: got m0_done=%b m1_done=%b, expected no completion", m0_done, m1_done);
      end else begin
        e = q.pop_front();
        chk("m0_done", 32'(m0_done), 32'(!e.gid));
        chk("m1_done", 32'(m1_done), 32'(e.gid));
        chk("rdata", e.gid ? m1_rdata : m0_rdata, e.rdata);
        chk("err", 32'(e.gid ? m1_err : m0_err), 32'(e.err));
        chk("other_err", 32'(e.gid ? m0_err : m1_err), 0);
        chk("read_complete", 32'(s_read_complete), 32'(e.rc));
      end
    end else if (s_read_complete) begin
      n_chk++;
      n_err++;
      $display("FAIL stray_read_complete: got 1 outside completion, expected 0");
    end
  end
  task automatic idle_masters();
    m0_addr = '0; m0_wdata = '0; m0_write_n = 2'b11; m0_read_n = 2'b11;
    m1_addr = '0; m1_wdata = '0; m1_write_n = 2'b11; m1_read_n = 2'b11;
  endtask
  task automatic rnd_cmd(input bit req, output logic [1:0] wn, output logic [1:0] rn);
    wn = 2'b11;
    rn = 2'b11;
    if (req) while (wn == 2'b11 && rn == 2'b11) begin
      wn = 2'($urandom);
      rn = 2'($urandom);
    end
  endtask
  task automatic check_idle_strobes(input string tag);
    chk({tag, "_s_write_n"}, 32'(s_write_n), 32'h3);
    chk({tag, "_s_read_n"}, 32'(s_read_n), 32'h3);
    chk({tag, "_s_addr"}, 32'(s_addr), 0);
    chk({tag, "_s_wdata"}, s_wdata, 0);
  endtask
  // one transfer from IDLE; delay = ACTIVE cycles before s_ready, >=16 never answers
  task automatic xfer(input logic [10:0] a0, input logic [10:0] a1, input logic [31:0] w0,
                      input logic [31:0] w1, input logic [1:0] wn0, input logic [1:0] rn0,
                      input logic [1:0] wn1, input logic [1:0] rn1, input int delay,
                      input logic [31:0] d, input int want_gid);
    bit r0, r1, w;
    logic [1:0] ewn, ern;
    logic [10:0] ea;
    logic [31:0] ew;
    exp_t e;
    int n;
    r0 = (wn0 != 2'b11) || (rn0 != 2'b11);
    r1 = (wn1 != 2'b11) || (rn1 != 2'b11);
    w = (r0 && r1) ? (last_served == 0) : r1;
    last_served = int'(w);
    ewn = w ? wn1 : wn0;
    ern = (ewn != 2'b11) ? 2'b11 : (w ? rn1 : rn0);
    ea = w ? a1 : a0;
    ew = w ? w1 : w0;
    e.gid = w;
    e.err = delay >= 16;
    e.rdata = e.err ? 32'hFFFF_FFFF : d;
    e.rc = !e.err && (ern != 2'b11);
    q.push_back(e);
    m0_addr = a0; m0_wdata = w0; m0_write_n = wn0; m0_read_n = rn0;
    m1_addr = a1; m1_wdata = w1; m1_write_n = wn1; m1_read_n = rn1;
    s_ready = 1'b0;
    @(posedge clk); #1;
    n = e.err ? 16 : delay + 1;
    for (int k = 0; k < n; k++) begin
      s_ready = (k == delay);
      s_rdata = (k == delay) ? d : $urandom;
      m0_addr = 11'($urandom); m0_wdata = $urandom; m0_write_n = 2'($urandom); m0_read_n = 2'($urandom);
      m1_addr = 11'($urandom); m1_wdata = $urandom; m1_write_n = 2'($urandom); m1_read_n = 2'($urandom);
      @(negedge clk);
      chk("busy_active", 32'(busy), 1);
      chk("grant_id", 32'(grant_id), 32'(w));
      if (want_gid >= 0) chk("tie_order", 32'(grant_id), want_gid);
      chk("s_addr", 32'(s_addr), 32'(ea));
      chk("s_wdata", s_wdata, ew);
      chk("s_write_n", 32'(s_write_n), 32'(ewn));
      chk("s_read_n", 32'(s_read_n), 32'(ern));
      chk("no_early_done", 32'(m0_done | m1_done), 0);
      @(posedge clk); #1;
    end
    idle_masters();
    s_ready = 1'b0;
    s_rdata = $urandom;
    @(negedge clk);
    chk("done_cycle", 32'(m0_done | m1_done), 1);
    chk("busy_done", 32'(busy), 1);
    check_idle_strobes("done");
    @(posedge clk); #1;
    @(negedge clk);
    chk("busy_idle", 32'(busy), 0);
    chk("no_done_idle", 32'(m0_done | m1_done), 0);
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no end of stimulus, expected finish before 2ms");
    $fatal(1, "watchdog expired");
  end
  initial begin
    bit [1:0] sel;
    logic [1:0] wn0, rn0, wn1, rn1;
    idle_masters();
    s_ready = 1'b0;
    s_rdata = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_grant", 32'(grant_id), 0);
    chk("rst_done", 32'({m0_done, m1_done, m0_err, m1_err}), 0);
    chk("rst_m0_rdata", m0_rdata, 0);
    chk("rst_m1_rdata", m1_rdata, 0);
    chk("rst_rc", 32'(s_read_complete), 0);
    check_idle_strobes("rst");
    xfer(11'h040, 11'h0, 32'hDEADBEEF, 32'h0, 2'b10, 2'b11, 2'b11, 2'b11, 0, 32'h1234_5678, 0);
    xfer(11'h0, 11'h123, 32'h0, 32'h0, 2'b11, 2'b11, 2'b11, 2'b00, 5, 32'h0000_00A5, 1);
    for (int i = 0; i < 4; i++)
      xfer(11'($urandom), 11'($urandom), $urandom, $urandom, 2'b11, 2'b10, 2'b11, 2'b10, 0, $urandom, i % 2);
    xfer(11'h055, 11'h0, 32'h0, 32'h0, 2'b11, 2'b10, 2'b11, 2'b11, 16, 32'h0, 0);
    chk("rdata_hold", m0_rdata, 32'hFFFF_FFFF);
    xfer(11'h0, 11'h066, 32'h0, 32'h0, 2'b11, 2'b11, 2'b11, 2'b10, 15, 32'hCAFE_F00D, 1);
    xfer(11'h010, 11'h0, 32'h0, 32'h0, 2'b11, 2'b10, 2'b11, 2'b11, 4, 32'h0BAD_BEEF, 0);
    xfer(11'h077, 11'h088, 32'h1, 32'h2, 2'b00, 2'b01, 2'b01, 2'b11, 0, 32'h3, -1);
    m0_addr = 11'h0AA; m0_read_n = 2'b10; m1_addr = 11'h0BB; m1_read_n = 2'b10;
    @(posedge clk); #1;
    idle_masters();
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    last_served = 1;
    @(negedge clk);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_no_done", 32'(m0_done | m1_done), 0);
    chk("abort_grant", 32'(grant_id), 0);
    check_idle_strobes("abort");
    xfer(11'h0CC, 11'h0DD, 32'h0, 32'h0, 2'b11, 2'b00, 2'b11, 2'b00, 1, 32'h5A5A_5A5A, 0);
    repeat (150) begin
      sel = 2'($urandom_range(1, 3));
      rnd_cmd(sel[0], wn0, rn0);
      rnd_cmd(sel[1], wn1, rn1);
      xfer(11'($urandom), 11'($urandom), $urandom, $urandom, wn0, rn0, wn1, rn1,
           int'($urandom_range(0, 19)), $urandom, -1);
    end
    chk("sb_drained", 32'(q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/periph_bus_arbiter.md
PERIPH_BUS_ARBITER -- requirements
Module: periph_bus_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16: maximum ACTIVE cycles to wait for s_ready before an error completion.
REQ-002 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have ports m0_addr/m1_addr  input  11  register address from master 0 (CPU) and master 1 (DMA/debug).
REQ-005 SHALL have ports m0_wdata/m1_wdata  input  32  write data.
REQ-006 SHALL have ports m0_write_n/m1_write_n and m0_read_n/m1_read_n  input  2 each  encoding: 11 idle, 00 byte, 01 half, 10 word.
REQ-007 SHALL have ports m0_rdata/m1_rdata  output  32  read data, valid while the matching done is high.
REQ-008 SHALL have ports m0_done/m1_done and m0_err/m1_err  output  1 each  one-cycle completion pulse and timeout flag.
REQ-009 SHALL have ports s_addr  output  11,  s_wdata  output  32,  s_write_n  output  2,  s_read_n  output  2  shared peripheral strobes.
REQ-010 SHALL have ports s_rdata  input  32,  s_ready  input  1,  s_read_complete  output  1  slave return path.
REQ-011 SHALL have ports busy  output  1  (state not IDLE) and grant_id  output  1  (master owning the bus).

Function
REQ-012 SHALL implement states IDLE, ACTIVE and DONE.
REQ-013 A master requests when its write_n or read_n is not 11; if both write_n and read_n are non-11, write SHALL take precedence and read is ignored.
REQ-014 In IDLE with at least one request, the arbiter SHALL latch the winner's addr/wdata/write_n/read_n, set grant_id and enter ACTIVE at that edge.
REQ-015 Arbitration SHALL be round-robin: with both requesting, the master not served last wins; last-served resets to 1, so m0 wins the first tie.
REQ-016 A single requester SHALL win regardless of last-served.
REQ-017 In ACTIVE, s_* SHALL drive the latched command; master inputs SHALL be ignored until DONE.
REQ-018 In IDLE and DONE, s_write_n and s_read_n SHALL be 11, s_addr 0 and s_wdata 0.
REQ-019 In ACTIVE, when s_ready is sampled high, the arbiter SHALL capture s_rdata and enter DONE.
REQ-020 A timeout counter SHALL clear on entry to ACTIVE and increment each ACTIVE cycle with s_ready low.
REQ-021 When the timeout counter reaches TIMEOUT_CYCLES, the arbiter SHALL enter DONE with err set and captured data 32'hFFFF_FFFF; s_ready high on that same cycle SHALL win (normal completion).
REQ-022 In DONE, for exactly one cycle, the granted master's done SHALL be 1, its rdata SHALL be the captured value and its err SHALL be the flag; the other master's done/err SHALL be 0.
REQ-023 s_read_complete SHALL be 1 in DONE only for non-error reads.
REQ-024 DONE SHALL always go to IDLE next; the earliest arbitration is the following cycle, giving 3 cycles per transfer with a zero-wait slave.
REQ-025 rdata outputs SHALL hold their last captured value outside DONE.
REQ-026 The timeout counter width SHALL be $clog2(TIMEOUT_CYCLES+1).

Reset
REQ-027 While rst is high at a rising clk edge, the arbiter SHALL enter IDLE with busy 0, grant_id 0, last-served 1, all done/err 0, rdata 0, s_read_complete 0 and s_* idle per REQ-018.
REQ-028 Reset in ACTIVE or DONE SHALL abort the transfer with no done pulse; strobes SHALL be idle from the cycle after the reset edge.

Structure
REQ-029 State encoding and the IDLE strobe constant 2'b11 SHALL live in shared package periph_bus_pkg.
REQ-030 The design SHALL be a single module with no sub-module; the arbitration decision and the timeout counter are inline.

Verification
REQ-031 m0 word write addr 0x040, data 0xDEADBEEF, with s_ready tied 1 -> s_write_n=10 for 1 cycle, m0_done high 2 cycles after the request, busy for 2 cycles.
REQ-032 m0 and m1 both request reads simultaneously, repeated 4 times -> grant order m0,m1,m0,m1 with no gap beyond the IDLE cycle.
REQ-033 m1 byte read with s_ready delayed 5 cycles and s_rdata 0x000000A5 -> m1_done with m1_rdata 0xA5, m1_err 0, s_read_complete pulse 1 cycle.
REQ-034 s_ready held 0, TIMEOUT_CYCLES=16 -> done after 16 ACTIVE cycles, err 1, rdata 0xFFFFFFFF, no s_read_complete.
REQ-035 rst asserted in the 3rd ACTIVE cycle -> no done pulse, strobes 11 on the next cycle, and the next tie goes to m0.
REQ-036 m0 changes addr from 0x010 to 0x020 mid-ACTIVE -> s_addr remains 0x010 until DONE.
